// File: rtl/shift_count_register.sv
// General-purpose datapath register: one-cycle clear/load/inc/dec with
// optional saturation, plus a serial (one bit per cycle) shift/rotate
// engine with a busy/done handshake and carry/zero/sign status.
module shift_count_register #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           SHAMT_WIDTH = 5,
  parameter bit                    SATURATE    = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cl,
  input  logic                   ld,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   sr,
  input  logic                   sl,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [1:0]             mode,
  input  logic                   ir,
  input  logic                   il,
  output logic [DATA_WIDTH-1:0]  out,
  output logic                   busy,
  output logic                   done,
  output logic                   carry,
  output logic                   zero,
  output logic                   neg
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   dir_left;
  logic [1:0]             shift_mode;
  logic                   right_fill;
  logic                   left_fill;
  logic                   all_ones;
  logic                   all_zero;

  assign all_ones = &out;
  assign all_zero = ~|out;

  // Status outputs derived directly from the register contents.
  assign busy = (state == SHIFT);
  assign zero = all_zero;
  assign neg  = out[DATA_WIDTH-1];

  // Bit shifted in at the vacated end, chosen by the captured shift mode
  // (mode 2'b11 falls into the logical default).
  always_comb begin
    right_fill = ir;
    left_fill  = il;
    case (shift_mode)
      2'b01: begin
        right_fill = out[DATA_WIDTH-1];
        left_fill  = 1'b0;
      end
      2'b10: begin
        right_fill = out[0];
        left_fill  = out[DATA_WIDTH-1];
      end
      default: begin
        right_fill = ir;
        left_fill  = il;
      end
    endcase
  end

  // Register, status and shift-sequencer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= RESET_VALUE;
      carry      <= 1'b0;
      done       <= 1'b0;
      state      <= IDLE;
      count      <= '0;
      dir_left   <= 1'b0;
      shift_mode <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cl) begin
            out   <= '0;
            carry <= 1'b0;
          end else if (ld) begin
            out   <= in;
            carry <= 1'b0;
          end else if (inc) begin
            carry <= all_ones;
            if (!(SATURATE && all_ones)) begin
              out <= out + DATA_WIDTH'(1);
            end
          end else if (dec) begin
            carry <= all_zero;
            if (!(SATURATE && all_zero)) begin
              out <= out - DATA_WIDTH'(1);
            end
          end else if (sr || sl) begin
            if (shamt == '0) begin
              done <= 1'b1;
            end else begin
              state      <= SHIFT;
              count      <= shamt;
              dir_left   <= !sr;
              shift_mode <= mode;
            end
          end
        end
        SHIFT: begin
          if (cl) begin
            out   <= '0;
            carry <= 1'b0;
            state <= IDLE;
          end else begin
            if (dir_left) begin
              out   <= {out[DATA_WIDTH-2:0], left_fill};
              carry <= out[DATA_WIDTH-1];
            end else begin
              out   <= {right_fill, out[DATA_WIDTH-1:1]};
              carry <= out[0];
            end
            count <= count - SHAMT_WIDTH'(1);
            if (count == SHAMT_WIDTH'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_count_register.sv
// Randomized bench for shift_count_register: two instances (wrapping and
// saturating) share one stimulus stream and are compared every cycle
// against an arithmetic reference model, plus directed scenario checks.
module tb_shift_count_register;

  localparam int unsigned W     = 16;
  localparam int unsigned SW    = 5;
  localparam int unsigned MAXV  = 32'h0000_FFFF;
  localparam logic [W-1:0] RV_SAT = 16'hA5C3;

  logic          clk = 1'b0;
  logic          rst, cl, ld, inc, dec, sr, sl, ir, il;
  logic [W-1:0]  in;
  logic [SW-1:0] shamt;
  logic [1:0]    mode;

  logic [W-1:0]  out_w, out_s;
  logic          busy_w, done_w, carry_w, zero_w, neg_w;
  logic          busy_s, done_s, carry_s, zero_s, neg_s;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state, index 0 = wrapping, 1 = saturating.
  int unsigned m_out[2];
  bit          m_carry[2];
  bit          m_busy[2];
  bit          m_done[2];
  bit          m_left[2];
  int unsigned m_mode[2];
  int unsigned m_rem[2];
  int unsigned m_rv[2];

  always #5 clk = ~clk;

  shift_count_register #(
    .DATA_WIDTH(W), .SHAMT_WIDTH(SW), .SATURATE(1'b0), .RESET_VALUE(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
    .sr(sr), .sl(sl), .shamt(shamt), .mode(mode), .ir(ir), .il(il),
    .out(out_w), .busy(busy_w), .done(done_w), .carry(carry_w),
    .zero(zero_w), .neg(neg_w)
  );

  shift_count_register #(
    .DATA_WIDTH(W), .SHAMT_WIDTH(SW), .SATURATE(1'b1), .RESET_VALUE(RV_SAT)
  ) dut_sat (
    .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
    .sr(sr), .sl(sl), .shamt(shamt), .mode(mode), .ir(ir), .il(il),
    .out(out_s), .busy(busy_s), .done(done_s), .carry(carry_s),
    .zero(zero_s), .neg(neg_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one model by one clock edge using the current inputs.
  task automatic model_step(input int m);
    bit sat = (m == 1);
    bit nd  = 1'b0;
    int unsigned fill;
    int unsigned md;
    if (rst) begin
      m_out[m] = m_rv[m]; m_carry[m] = 0; m_busy[m] = 0; m_done[m] = 0;
      return;
    end
    if (!m_busy[m]) begin
      if (cl) begin
        m_out[m] = 0; m_carry[m] = 0;
      end else if (ld) begin
        m_out[m] = in; m_carry[m] = 0;
      end else if (inc) begin
        if (m_out[m] == MAXV) begin
          m_carry[m] = 1; m_out[m] = sat ? MAXV : 0;
        end else begin
          m_carry[m] = 0; m_out[m] = m_out[m] + 1;
        end
      end else if (dec) begin
        if (m_out[m] == 0) begin
          m_carry[m] = 1; m_out[m] = sat ? 0 : MAXV;
        end else begin
          m_carry[m] = 0; m_out[m] = m_out[m] - 1;
        end
      end else if (sr || sl) begin
        if (shamt == 0) nd = 1;
        else begin
          m_busy[m] = 1; m_left[m] = !sr; m_mode[m] = mode; m_rem[m] = shamt;
        end
      end
    end else if (cl) begin
      m_out[m] = 0; m_carry[m] = 0; m_busy[m] = 0;
    end else begin
      md = (m_mode[m] == 3) ? 0 : m_mode[m];
      if (!m_left[m]) begin
        if (md == 1)      fill = (m_out[m] >> (W-1)) & 1;
        else if (md == 2) fill = m_out[m] & 1;
        else              fill = ir;
        m_carry[m] = m_out[m] & 1;
        m_out[m]   = (m_out[m] >> 1) | (fill << (W-1));
      end else begin
        m_carry[m] = (m_out[m] >> (W-1)) & 1;
        if (md == 1)      fill = 0;
        else if (md == 2) fill = m_carry[m];
        else              fill = il;
        m_out[m] = ((m_out[m] << 1) & MAXV) | fill;
      end
      m_rem[m]--;
      if (m_rem[m] == 0) begin
        m_busy[m] = 0; nd = 1;
      end
    end
    m_done[m] = nd;
  endtask

  task automatic compare_all();
    check("out_w",   32'(out_w),   m_out[0]);
    check("carry_w", 32'(carry_w), 32'(m_carry[0]));
    check("busy_w",  32'(busy_w),  32'(m_busy[0]));
    check("done_w",  32'(done_w),  32'(m_done[0]));
    check("zero_w",  32'(zero_w),  32'(m_out[0] == 0));
    check("neg_w",   32'(neg_w),   (m_out[0] >> (W-1)) & 1);
    check("out_s",   32'(out_s),   m_out[1]);
    check("carry_s", 32'(carry_s), 32'(m_carry[1]));
    check("busy_s",  32'(busy_s),  32'(m_busy[1]));
    check("done_s",  32'(done_s),  32'(m_done[1]));
    check("zero_s",  32'(zero_s),  32'(m_out[1] == 0));
    check("neg_s",   32'(neg_s),   (m_out[1] >> (W-1)) & 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic clr_cmds();
    rst = 0; cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0;
    ir = 0; il = 0; shamt = '0; mode = 2'b00;
  endtask

  task automatic load(input logic [W-1:0] v);
    clr_cmds(); ld = 1; in = v; cyc(); ld = 0;
  endtask

  initial begin
    m_rv[0] = 0; m_rv[1] = RV_SAT;
    for (int m = 0; m < 2; m++) begin
      m_out[m] = 0; m_carry[m] = 0; m_busy[m] = 0; m_done[m] = 0;
      m_left[m] = 0; m_mode[m] = 0; m_rem[m] = 0;
    end
    clr_cmds(); in = '0;

    // Reset dominates a simultaneous load.
    rst = 1; ld = 1; in = 16'h1234;
    cyc(); cyc();
    check("tp1_out", 32'(out_w), 32'h0);
    check("tp1_zero", 32'(zero_w), 32'h1);
    check("tp1_rv_sat", 32'(out_s), 32'(RV_SAT));

    // Increment past all-ones, decrement below zero.
    load(16'hFFFF);
    inc = 1; cyc(); inc = 0;
    check("tp2_wrap", 32'(out_w), 32'h0);
    check("tp2_wrap_c", 32'(carry_w), 32'h1);
    check("tp2_sat", 32'(out_s), 32'hFFFF);
    check("tp2_sat_c", 32'(carry_s), 32'h1);
    cl = 1; cyc(); cl = 0;
    dec = 1; cyc(); dec = 0;
    check("tp2_dec_sat", 32'(out_s), 32'h0);
    check("tp2_dec_sat_c", 32'(carry_s), 32'h1);
    check("tp2_dec_wrap", 32'(out_w), 32'hFFFF);

    // Arithmetic and rotate right by 4.
    for (int k = 0; k < 2; k++) begin
      load(16'h8001);
      sr = 1; shamt = 5'd4; mode = (k == 0) ? 2'b01 : 2'b10;
      cyc(); clr_cmds();
      for (int i = 0; i < 4; i++) begin
        check("tp3_busy", 32'(busy_w), 32'h1);
        cyc();
      end
      check("tp3_out", 32'(out_w), (k == 0) ? 32'hF800 : 32'h1800);
      check("tp3_carry", 32'(carry_w), 32'h0);
      check("tp3_done", 32'(done_w), 32'h1);
      cyc();
      check("tp3_done_low", 32'(done_w), 32'h0);
    end

    // Logical left by 3 with il=1; inc during busy is ignored.
    load(16'h00F0);
    sl = 1; shamt = 5'd3; mode = 2'b00; il = 1;
    cyc(); sl = 0; inc = 1;
    for (int i = 0; i < 3; i++) cyc();
    clr_cmds();
    check("tp4_out", 32'(out_w), 32'h0787);
    check("tp4_carry", 32'(carry_w), 32'h0);

    // Abort a 10-bit shift by clear, then by reset.
    for (int k = 0; k < 2; k++) begin
      load(16'hBEEF);
      sr = 1; shamt = 5'd10; cyc(); clr_cmds();
      cyc(); cyc();
      if (k == 0) cl = 1; else rst = 1;
      cyc(); clr_cmds();
      check("tp5_out", 32'(out_w), 32'h0);
      check("tp5_busy", 32'(busy_w), 32'h0);
      check("tp5_done", 32'(done_w), 32'h0);
      cyc();
      check("tp5_done2", 32'(done_w), 32'h0);
    end

    // Priority and zero-length shift.
    load(16'h7777);
    cl = 1; ld = 1; inc = 1; in = 16'h0005; cyc(); clr_cmds();
    check("tp6_cl_prio", 32'(out_w), 32'h0);
    ld = 1; inc = 1; in = 16'h0005; cyc(); clr_cmds();
    check("tp6_ld_prio", 32'(out_w), 32'h5);
    sr = 1; shamt = '0; cyc(); clr_cmds();
    check("tp6_sh0_done", 32'(done_w), 32'h1);
    check("tp6_sh0_busy", 32'(busy_w), 32'h0);
    check("tp6_sh0_out", 32'(out_w), 32'h5);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int unsigned pick;
      rst = ($urandom_range(0, 99) == 0);
      cl  = ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      inc = ($urandom_range(0, 3) == 0);
      dec = ($urandom_range(0, 3) == 0);
      sr  = ($urandom_range(0, 4) == 0);
      sl  = ($urandom_range(0, 4) == 0);
      ir  = $urandom_range(0, 1);
      il  = $urandom_range(0, 1);
      mode = 2'($urandom_range(0, 3));
      shamt = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 31))
                                          : SW'($urandom_range(0, 6));
      pick = $urandom_range(0, 4);
      case (pick)
        0: in = 16'h0000;
        1: in = 16'hFFFF;
        2: in = 16'h8000;
        3: in = 16'h7FFF;
        default: in = 16'($urandom);
      endcase
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_count_register.md
Name: shift_count_register

Overview:
General-purpose datapath register, the parametrised successor of the single-step register.
- Load, clear, increment and decrement complete in one cycle; optional saturation.
- Multi-bit shift/rotate executes serially, one bit per cycle, with a busy/done handshake.
- Carry, zero and sign status outputs for the control unit.

Parameters:
DATA_WIDTH, 16, register width in bits (>=2)
SHAMT_WIDTH, 5, width of shift-amount input; shifts of 0..2^SHAMT_WIDTH-1 bits
SATURATE, 0, 1 = inc/dec clamp at all-ones/zero instead of wrapping
RESET_VALUE, 0, value loaded into out on rst

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
cl  input  1  clear out to 0
ld  input  1  load in
in  input  DATA_WIDTH  parallel load data
inc  input  1  out+1
dec  input  1  out-1
sr  input  1  start right shift of shamt bits
sl  input  1  start left shift of shamt bits
shamt  input  SHAMT_WIDTH  shift amount, sampled at shift start
mode  input  2  shift mode, sampled at start: 00 logical, 01 arithmetic, 10 rotate, 11 treated as 00
ir  input  1  serial bit into MSB on logical sr, sampled every shift cycle
il  input  1  serial bit into LSB on logical sl, sampled every shift cycle
out  output  DATA_WIDTH  register contents
busy  output  1  serial shift in progress
done  output  1  one-cycle pulse, shift complete
carry  output  1  registered carry/borrow/last shifted-out bit
zero  output  1  out == 0 (combinational from out)
neg  output  1  out[DATA_WIDTH-1]

Behaviour:
- Reset: synchronous, active-high; rst dominates every other input.
  - out=RESET_VALUE, state=IDLE, busy=0, done=0, carry=0.
  - Reset mid-shift aborts the shift with no done pulse.
- States: IDLE, SHIFT. busy=1 exactly in SHIFT. done is a registered output.
- IDLE command priority: cl > ld > inc > dec > sr > sl. Only the highest asserted command executes.
  - cl: out=0, carry=0.
  - ld: out=in, carry=0.
  - inc: out=out+1; carry = carry-out (1 when out was all-ones).
    - SATURATE=1: all-ones holds, carry=1.
  - dec: out=out-1; carry = borrow (1 when out was 0).
    - SATURATE=1: 0 holds, carry=1.
  - sr/sl: capture direction, mode, count=shamt; go to SHIFT; out unchanged this edge.
    - shamt=0: stay IDLE; done=1 next cycle; out and carry unchanged.
- SHIFT: one bit per rising edge; count decrements each step.
  - Right step:
    - out = {fill, out[HIGH:1]}; carry = old out[0].
    - fill = ir (logical), old out[HIGH] (arithmetic), old out[0] (rotate).
  - Left step:
    - out = {out[HIGH-1:0], fill}; carry = old out[HIGH].
    - fill = il (logical), 0 (arithmetic), old out[HIGH] (rotate).
  - On the step where count reaches 0: return to IDLE; done=1 for the following cycle.
    - n-bit shift: busy high n cycles; done in cycle n+1 after the start edge.
  - shamt >= DATA_WIDTH is legal; the shift simply runs that many steps.
  - During SHIFT: ld, inc, dec, sr, sl are ignored (not queued).
    - cl aborts: out=0, carry=0, IDLE, no done pulse.
- done is 0 in all cycles except the completion pulse. A new command is accepted in the same cycle done is high.
- zero and neg are combinational from out and carry no extra latency.

Test Plan:
1. rst=1 with ld=1, in=16'h1234 -> next cycle out=RESET_VALUE (0), busy=0, done=0, carry=0, zero=1.
2. ld 16'hFFFF, then inc -> out=16'h0000, carry=1, zero=1. With SATURATE=1: out stays 16'hFFFF, carry=1. Then dec from 0 with SATURATE=1 -> out=0, carry=1.
3. Load 16'h8001; sr, shamt=4, mode=01 -> busy high 4 cycles; out=16'hF800, carry=0, done pulses 1 cycle after busy falls. Repeat with mode=10 -> out=16'h1800.
4. Load 16'h00F0; sl, shamt=3, mode=00, il=1 every cycle -> out=16'h0787, carry=0. inc asserted during busy is ignored (out unaffected).
5. Start a 10-bit shift; at step 3 assert cl -> out=0, busy=0, no done. Repeat with rst at step 3 -> out=RESET_VALUE, no done.
6. Simultaneous cl+ld+inc -> out=0. ld+inc with in=5 -> out=5. sr with shamt=0 -> out unchanged, done pulses next cycle, busy never set.
